lfsr_rate_encoder: RTL and testbench

Parametrised Poisson-style rate encoder, the next generation of the 4-channel fixed LFSR spike generator. Each frame it reads N_WORDS words of packed pixels from image BRAM and emits one spike per channel per word by comparing a gain-scaled pixel against a per-channel LFSR sample. It sits between image BRAM and the SNN weight/neuron core. It adds channel, width and depth generalisation, a runtime seed load, an abort, and a frame-done pulse.

---
 rtl/lfsr_enc_pkg.sv | 45 ++++
 rtl/lfsr_enc_ch.sv | 62 ++++++
 rtl/lfsr_rate_encoder.sv | 143 ++++++++++++++
 tb/tb_lfsr_rate_encoder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_enc_pkg.sv
// lfsr_enc_pkg: shared state encoding and helper functions for the LFSR rate
// encoder. Functions work on a 32-bit container and take the active width.
package lfsr_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int MAX_W = 32;

    // Fibonacci feedback taps for the supported LFSR widths.
    function automatic logic [MAX_W-1:0] tap_mask(input int width);
        case (width)
            8:       return 32'h0000_00B8;   // bits 7,5,4,3
            16:      return 32'h0000_B400;   // bits 15,13,12,10
            24:      return 32'h00E1_0000;   // bits 23,22,21,16
            32:      return 32'h8020_0003;   // bits 31,21,1,0
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Reverse the low 'width' bits; upper bits return as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] value,
                                                     input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < width; i++) r[i] = value[width-1-i];
        return r;
    endfunction

    // Keep the low 'width' bits of a raw seed; an all-zero result would lock
    // the LFSR, so it becomes 1.
    function automatic logic [MAX_W-1:0] seed_derive(input logic [MAX_W-1:0] raw,
                                                     input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < width; i++) v[i] = raw[i];
        if (v == '0) v = {{(MAX_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

endpackage

// File: rtl/lfsr_enc_ch.sv
// lfsr_enc_ch: one encoder channel. Holds the channel LFSR, applies its reset
// seed or a loaded seed, steps it, and registers the pixel-vs-random compare.
module lfsr_enc_ch
    import lfsr_enc_pkg::*;
#(
    parameter int CH        = 0,
    parameter int PIX_W     = 8,
    parameter int LFSR_W    = 16,
    parameter int GAIN_SH   = 2,
    parameter int SEED_STEP = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_abort,
    input  logic              i_seed_ld,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_step,
    input  logic [PIX_W-1:0]  i_pix,
    output logic              o_spike
);

    localparam logic [LFSR_W-1:0] RST_SEED =
        LFSR_W'(seed_derive(MAX_W'((CH + 1) * SEED_STEP), LFSR_W));
    localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(tap_mask(LFSR_W));
    localparam logic [LFSR_W-1:0] CH_OFS = LFSR_W'(CH * SEED_STEP);

    logic [LFSR_W-1:0] r_lfsr;
    logic              r_spike;
    logic [LFSR_W-1:0] w_rand;
    logic [LFSR_W-1:0] w_level;
    logic [LFSR_W-1:0] w_next;
    logic [LFSR_W-1:0] w_seed;
    logic              w_fb;

    // Random sample, gain-scaled pixel, next LFSR value and loadable seed.
    always_comb begin
        w_rand  = LFSR_W'(bit_reverse(MAX_W'(r_lfsr), LFSR_W));
        w_level = LFSR_W'(i_pix) << GAIN_SH;
        w_fb    = ^(r_lfsr & TAPS);
        w_next  = {r_lfsr[LFSR_W-2:0], w_fb};
        w_seed  = LFSR_W'(seed_derive(MAX_W'(i_seed ^ CH_OFS), LFSR_W));
    end

    // LFSR and spike register; abort drops the spike but keeps the LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the LFSR needs a nonzero reset value; all-zero never leaves zero.
            r_lfsr  <= RST_SEED;
            r_spike <= 1'b0;
        end else if (i_abort) begin
            r_spike <= 1'b0;
        end else begin
            // NOTE: non-blocking so the compare uses the pre-step LFSR value.
            if (i_seed_ld)   r_lfsr <= w_seed;
            else if (i_step) r_lfsr <= w_next;
            r_spike <= i_step && (w_level > w_rand);
        end
    end

    assign o_spike = r_spike;

endmodule

// File: rtl/lfsr_rate_encoder.sv
// lfsr_rate_encoder: frame FSM, word counter and two-stage pipeline around
// N_CH lfsr_enc_ch channels. Define LFSR_RATE_SPIKE_CNT_EN to build the
// per-channel saturating spike counters; otherwise o_spike_cnt is 0.
module lfsr_rate_encoder
    import lfsr_enc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PIX_W     = 8,
    parameter int LFSR_W    = 16,
    parameter int N_WORDS   = 144,
    parameter int ADDR_W    = 8,
    parameter int GAIN_SH   = 2,
    parameter int SEED_STEP = 10000,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic                  i_rest_run,
    input  logic                  i_abort,
    input  logic                  i_seed_ld,
    input  logic [LFSR_W-1:0]     i_seed,
    output logic [N_CH-1:0]       o_spike,
    output logic                  o_w_run,
    output logic                  o_valid,
    output logic                  o_done,
    output logic                  o_busy,
    output logic [ADDR_W-1:0]     o_addr,
    output logic                  o_ce,
    input  logic [N_CH*PIX_W-1:0] i_q,
    output logic [N_CH*CNT_W-1:0] o_spike_cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

    state_t            r_state;
    state_t            w_next_state;
    state_t            r_s0;
    state_t            r_s1;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_start;
    logic              w_seed_ld;
    logic              w_step;
    logic              w_act0;
    logic              w_act1;
    logic [N_CH-1:0]   w_spike;

    assign w_start   = (r_state == ST_IDLE) && (i_run || i_rest_run) && !i_abort;
    assign w_seed_ld = (r_state == ST_IDLE) && i_seed_ld && !i_abort;
    assign w_step    = (r_s0 == ST_RUN);
    assign w_act0    = (r_s0 == ST_RUN) || (r_s0 == ST_REST);
    assign w_act1    = (r_s1 == ST_RUN) || (r_s1 == ST_REST);

    // Next-state logic; rest wins over run, abort overrides everything.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next_state unset (no latch).
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:         if (w_start) w_next_state = i_rest_run ? ST_REST : ST_RUN;
            ST_RUN, ST_REST: if (r_cnt == LAST) w_next_state = ST_DONE;
            ST_DONE:         w_next_state = ST_IDLE;
            default:         w_next_state = ST_IDLE;
        endcase
        if (i_abort) w_next_state = ST_IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Word counter: counts through RUN/REST, cleared in DONE and on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        r_cnt <= '0;
        else if (i_abort || r_state == ST_DONE)            r_cnt <= '0;
        else if (r_state == ST_RUN || r_state == ST_REST)  r_cnt <= r_cnt + ADDR_W'(1);
    end

    // State delay line tracking BRAM latency (s0) and the spike register (s1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0 <= ST_IDLE;
            r_s1 <= ST_IDLE;
        end else if (i_abort) begin
            r_s0 <= ST_IDLE;
            r_s1 <= ST_IDLE;
        end else begin
            r_s0 <= r_state;
            r_s1 <= r_s0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lfsr_enc_ch #(
            .CH        (g),
            .PIX_W     (PIX_W),
            .LFSR_W    (LFSR_W),
            .GAIN_SH   (GAIN_SH),
            .SEED_STEP (SEED_STEP)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_abort   (i_abort),
            .i_seed_ld (w_seed_ld),
            .i_seed    (i_seed),
            .i_step    (w_step),
            .i_pix     (i_q[g*PIX_W +: PIX_W]),
            .o_spike   (w_spike[g])
        );
    end

    assign o_spike = w_spike;
    assign o_valid = w_act1;
    assign o_w_run = w_act0 && !w_act1;
    assign o_done  = (r_s1 == ST_DONE);
    assign o_busy  = (r_state != ST_IDLE) || (r_s0 != ST_IDLE) || (r_s1 != ST_IDLE);
    assign o_addr  = r_cnt;
    assign o_ce    = (r_state == ST_RUN);

`ifdef LFSR_RATE_SPIKE_CNT_EN
    logic [N_CH*CNT_W-1:0] r_spike_cnt;

    // Saturating per-channel spike counters, cleared when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_cnt <= '0;
        end else if (w_start) begin
            r_spike_cnt <= '0;
        end else if (w_act1) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (w_spike[ch] && (r_spike_cnt[ch*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                    r_spike_cnt[ch*CNT_W +: CNT_W] <= r_spike_cnt[ch*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    assign o_spike_cnt = r_spike_cnt;
`else
    assign o_spike_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_rate_encoder.sv
// tb_lfsr_rate_encoder: scoreboard bench. A BRAM model pushes the expected
// spike vector for every word it serves; a monitor pops it on each o_valid.
module tb_lfsr_rate_encoder;

    localparam int N_CH    = 4;
    localparam int PIX_W   = 8;
    localparam int LFSR_W  = 16;
    localparam int N_WORDS = 144;
    localparam int ADDR_W  = 8;
    localparam int GAIN_SH = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  i_run, i_rest_run, i_abort, i_seed_ld;
    logic [LFSR_W-1:0]     i_seed;
    logic [N_CH-1:0]       o_spike;
    logic                  o_w_run, o_valid, o_done, o_busy, o_ce;
    logic [ADDR_W-1:0]     o_addr;
    logic [N_CH*PIX_W-1:0] i_q;
    logic [N_CH*CNT_W-1:0] o_spike_cnt;

    int errors = 0;
    int checks = 0;

    logic [N_CH*PIX_W-1:0] mem [N_WORDS];
    logic [LFSR_W-1:0]     m_lfsr [N_CH];
    int                    m_cnt [N_CH];
    logic [N_CH-1:0]       exp_q [$];

    lfsr_rate_encoder #(
        .N_CH(N_CH), .PIX_W(PIX_W), .LFSR_W(LFSR_W), .N_WORDS(N_WORDS),
        .ADDR_W(ADDR_W), .GAIN_SH(GAIN_SH), .SEED_STEP(10000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_rest_run(i_rest_run),
        .i_abort(i_abort), .i_seed_ld(i_seed_ld), .i_seed(i_seed),
        .o_spike(o_spike), .o_w_run(o_w_run), .o_valid(o_valid), .o_done(o_done),
        .o_busy(o_busy), .o_addr(o_addr), .o_ce(o_ce), .i_q(i_q),
        .o_spike_cnt(o_spike_cnt)
    );

    always #5 clk = ~clk;

    // Golden 16-bit Fibonacci LFSR, taps 15,13,12,10, shift left.
    function automatic logic [15:0] m_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] m_rev(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15-i];
        return r;
    endfunction

    // BRAM with one-cycle latency; also predicts the spike for each word read.
    initial begin : bram
        logic [N_CH-1:0]       e;
        logic [15:0]           lvl;
        logic [N_CH*PIX_W-1:0] w;
        forever begin
            @(posedge clk);
            if (rst_n && o_ce) begin
                w = mem[o_addr];
                for (int ch = 0; ch < N_CH; ch++) begin
                    lvl       = 16'(w[ch*PIX_W +: PIX_W]) << GAIN_SH;
                    e[ch]     = lvl > m_rev(m_lfsr[ch]);
                    m_lfsr[ch] = m_step(m_lfsr[ch]);
                    if (e[ch] && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
                end
                exp_q.push_back(e);
                i_q <= w;
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        logic [N_CH-1:0] exp_s;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spike_extra: o_valid high with o_spike=%b, no step expected", o_spike);
                    end else begin
                        exp_s = exp_q.pop_front();
                        if (o_spike !== exp_s) begin
                            errors++;
                            $display("FAIL spike_step: o_spike=%b required=%b at %0t", o_spike, exp_s, $time);
                        end
                    end
                end else if (o_spike !== '0) begin
                    errors++;
                    $display("FAIL spike_idle: o_spike=%b required=0 while o_valid low", o_spike);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset_seeds();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_lfsr[ch] = 16'((ch + 1) * 10000);
            if (m_lfsr[ch] == 16'd0) m_lfsr[ch] = 16'd1;
        end
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < N_WORDS; i++)
            mem[i] = (mode == 0) ? '0 : (mode == 1) ? '1 : (N_CH*PIX_W)'($urandom());
    endtask

    task automatic load_seed(input logic [15:0] seed);
        i_seed = seed; i_seed_ld = 1'b1;
        tick();
        i_seed_ld = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_lfsr[ch] = seed ^ 16'(ch * 10000);
            if (m_lfsr[ch] == 16'd0) m_lfsr[ch] = 16'd1;
        end
    endtask

    // Drive a start for one cycle; returns in cycle 1 of the frame.
    task automatic start_frame(input logic run, input logic rest);
        i_run = run; i_rest_run = rest;
        tick();
        i_run = 1'b0; i_rest_run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 400) begin tick(); n++; end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL %s_timeout: o_busy=1 after %0d cycles, required 0", name, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected steps not produced, required 0", name, exp_q.size());
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        logic [N_CH+6+ADDR_W+N_CH*CNT_W-1:0] got;
        rst_n = 1'b0;
        #2;
        got = {o_spike, o_w_run, o_valid, o_done, o_busy, o_ce, 1'b0, o_addr, o_spike_cnt};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h required 0", got);
        end
        #10 rst_n = 1'b1;
        tick();
        // Mid-frame reset at cnt=60.
        fill_mem(2);
        start_frame(1'b1, 1'b0);
        for (int n = 0; n < 200 && !(o_ce && o_addr == 8'd60); n++) tick();
        checks++;
        if (!(o_ce && o_addr == 8'd60)) begin
            errors++;
            $display("FAIL reset_reach: o_addr=%0d o_ce=%b, required 60/1", o_addr, o_ce);
        end
        #3 rst_n = 1'b0;
        #1;
        got = {o_spike, o_w_run, o_valid, o_done, o_busy, o_ce, 1'b0, o_addr, o_spike_cnt};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_midframe: outputs=%h required 0", got);
        end
        #2 rst_n = 1'b1;
        exp_q.delete();
        model_reset_seeds();
        tick();
        // Spikes of this frame only match if the LFSRs restarted from reset seeds.
        fill_mem(2);
        start_frame(1'b1, 1'b0);
        wait_idle("reset_seeds");
    endtask

    task automatic test_timing();
        logic [3:0] got, exp;
        fill_mem(0);
        start_frame(1'b1, 1'b0);
        for (int k = 1; k <= 150; k++) begin
            got = {o_ce, o_w_run, o_valid, o_done};
            exp = {k <= 144, k == 2, k >= 3 && k <= 146, k == 147};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timing_cycle%0d: ce/w_run/valid/done=%b required %b", k, got, exp);
            end
            if (k <= 144) begin
                checks++;
                if (o_addr !== ADDR_W'(k - 1)) begin
                    errors++;
                    $display("FAIL timing_addr: cycle %0d o_addr=%0d required %0d", k, o_addr, k - 1);
                end
            end
            tick();
        end
        wait_idle("timing");
    endtask

    task automatic test_rest();
        logic [2:0] got, exp;
        fill_mem(1);
        for (int i = 0; i < N_WORDS; i++) exp_q.push_back('0);
        start_frame(1'b1, 1'b1);
        for (int k = 1; k <= 150; k++) begin
            got = {o_ce, o_valid, o_done};
            exp = {1'b0, k >= 3 && k <= 146, k == 147};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rest_cycle%0d: ce/valid/done=%b required %b", k, got, exp);
            end
            tick();
        end
        wait_idle("rest");
    endtask

    task automatic test_gain_seed();
        fill_mem(1);
        load_seed(16'h1234);
        start_frame(1'b1, 1'b0);
        wait_idle("seed_frame1");
        load_seed(16'h1234);
        start_frame(1'b1, 1'b0);
        wait_idle("seed_frame2");
        // A zero seed must be substituted by 1 for channel 0.
        fill_mem(2);
        load_seed(16'h0000);
        start_frame(1'b1, 1'b0);
        wait_idle("seed_zero");
    endtask

    task automatic test_abort();
        int n_valid = 0;
        int n_done  = 0;
        fill_mem(2);
        start_frame(1'b1, 1'b0);
        for (int k = 1; k < 30; k++) tick();
        // Seed load while running must be ignored; the model is not reseeded.
        i_seed = 16'hAAAA; i_seed_ld = 1'b1;
        tick();
        i_seed_ld = 1'b0;
        wait_idle("seed_in_run");
        start_frame(1'b1, 1'b0);
        for (int n = 0; n < 200 && !(o_ce && o_addr == 8'd50); n++) tick();
        checks++;
        if (!(o_ce && o_addr == 8'd50)) begin
            errors++;
            $display("FAIL abort_reach: o_addr=%0d o_ce=%b, required 50/1", o_addr, o_ce);
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        exp_q.delete();
        checks++;
        if ({o_valid, o_spike, o_busy, o_ce} !== '0) begin
            errors++;
            $display("FAIL abort_next: valid=%b spike=%b busy=%b ce=%b, required all 0",
                     o_valid, o_spike, o_busy, o_ce);
        end
        for (int k = 0; k < 160; k++) begin
            n_valid += int'(o_valid);
            n_done  += int'(o_done);
            tick();
        end
        checks++;
        if (n_valid != 0 || n_done != 0) begin
            errors++;
            $display("FAIL abort_quiet: valid cycles=%0d done pulses=%0d, required 0/0", n_valid, n_done);
        end
        load_seed(16'hBEEF);
        start_frame(1'b1, 1'b0);
        checks++;
        if (!(o_ce && o_addr == 8'd0)) begin
            errors++;
            $display("FAIL abort_restart: o_ce=%b o_addr=%0d, required 1/0", o_ce, o_addr);
        end
        wait_idle("abort_restart");
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        int n_ce    = 0;
        int n_done  = 0;
        int done_at [$];
        fill_mem(2);
        i_run = 1'b1;
        tick();
        for (int k = 1; k <= 300; k++) begin
            if (k == 147) i_run = 1'b0;
            n_valid += int'(o_valid);
            n_ce    += int'(o_ce);
            if (o_done) begin n_done++; done_at.push_back(k); end
            tick();
        end
        checks++;
        if (n_valid != 288 || n_ce != 288) begin
            errors++;
            $display("FAIL b2b_counts: valid=%0d ce=%0d, required 288/288", n_valid, n_ce);
        end
        checks++;
        if (n_done != 2 || done_at[0] != 147 || done_at[1] != 293) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses, first at %0d, required 2 at 147 and 293",
                     n_done, (n_done > 0) ? done_at[0] : -1);
        end
        wait_idle("b2b");
    endtask

    task automatic test_spike_cnt();
        logic [N_CH*CNT_W-1:0] exp_cnt;
        fill_mem(1);
        load_seed(16'h5A5A);
        for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
        start_frame(1'b1, 1'b0);
        checks++;
        if (o_spike_cnt !== '0) begin
            errors++;
            $display("FAIL cnt_clear_run: o_spike_cnt=%h required 0", o_spike_cnt);
        end
        wait_idle("cnt_frame");
`ifdef LFSR_RATE_SPIKE_CNT_EN
        for (int ch = 0; ch < N_CH; ch++) exp_cnt[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
`else
        exp_cnt = '0;
`endif
        checks++;
        if (o_spike_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL cnt_saturate: o_spike_cnt=%h required %h", o_spike_cnt, exp_cnt);
        end
        for (int i = 0; i < N_WORDS; i++) exp_q.push_back('0);
        start_frame(1'b0, 1'b1);
        checks++;
        if (o_spike_cnt !== '0) begin
            errors++;
            $display("FAIL cnt_clear_next: o_spike_cnt=%h required 0", o_spike_cnt);
        end
        wait_idle("cnt_rest");
        checks++;
        if (o_spike_cnt !== '0) begin
            errors++;
            $display("FAIL cnt_rest_hold: o_spike_cnt=%h required 0", o_spike_cnt);
        end
    endtask

    initial begin
        i_run = 1'b0; i_rest_run = 1'b0; i_abort = 1'b0;
        i_seed_ld = 1'b0; i_seed = '0;
        for (int ch = 0; ch < N_CH; ch++) m_cnt[ch] = 0;
        model_reset_seeds();
        test_reset();
        test_timing();
        test_rest();
        test_gain_seed();
        test_abort();
        test_back_to_back();
        test_spike_cnt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
